// File: rtl/adder_4bit_pkg.sv
// adder_4bit_pkg: reset values of the registered adder outputs.
package adder_4bit_pkg;
   localparam logic [3:0] SUM_RST   = 4'b0000;
   localparam logic       COUT_RST  = 1'b0;
   localparam logic       OVF_RST   = 1'b0;
   localparam logic       ZERO_RST  = 1'b1;
   localparam logic       VALID_RST = 1'b0;
endpackage

// File: rtl/adder_4bit_full_adder.sv
// full_adder: single-bit combinational full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic p;
   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/adder_4bit.sv
// adder_4bit: registered 4-bit ripple-carry adder with carry-out, signed overflow and zero flags.
module adder_4bit
   import adder_4bit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout,
   output logic       ovf,
   output logic       zero,
   output logic       valid
);
   localparam int WIDTH = 4;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, valid_q, valid_d;
   assign c[0] = cin;
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .sum (s[i]),
         .cout(c[i+1])
      );
   end
   // Flags come from the core this cycle; disabled cycles hold the last result.
   always_comb begin
      sum_d   = en ? s : sum_q;
      cout_d  = en ? c[WIDTH] : cout_q;
      ovf_d   = en ? c[WIDTH-1] ^ c[WIDTH] : ovf_q;
      zero_d  = en ? ~|s : zero_q;
      valid_d = en;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= SUM_RST;
         cout_q  <= COUT_RST;
         ovf_q   <= OVF_RST;
         zero_q  <= ZERO_RST;
         valid_q <= VALID_RST;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign ovf   = ovf_q;
   assign zero  = zero_q;
   assign valid = valid_q;
endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: scoreboard bench for the registered 4-bit adder.
module tb_adder_4bit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic [3:0] sum;
   logic       cout, ovf, zero, valid;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] sb_q[$];
   logic [7:0] exp_v, got_v, last_v;

   adder_4bit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf),
      .zero (zero),
      .valid(valid)
   );

   always #5 clk = ~clk;

   // Expected {valid, sum, cout, ovf, zero}; overflow from signed arithmetic range.
   function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
      int u, sg;
      u  = int'(x) + int'(y) + int'(ci);
      sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
      return {1'b1, 4'(u), u > 15, (sg > 7) || (sg < -8), 4'(u) == 4'd0};
   endfunction

   task automatic drive(input logic e, input logic [3:0] x, input logic [3:0] y, input logic ci);
      @(negedge clk);
      en = e; a = x; b = y; cin = ci;
      if (e) begin
         last_v = model(x, y, ci);
         sb_q.push_back(last_v);
      end else
         sb_q.push_back({1'b0, last_v[6:0]});
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      #2;
      en = 1'b1; a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid, sum, cout, ovf, zero} !== 8'b0_0000_001) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", {valid, sum, cout, ovf, zero}, 8'b0_0000_001);
      end
      @(posedge clk); #1;
      checks++;
      if ({valid, sum, cout, ovf, zero} !== 8'b0_0000_001) begin
         failures++;
         $display("FAIL reset_held got=%b exp=%b", {valid, sum, cout, ovf, zero}, 8'b0_0000_001);
      end
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;
      last_v = 8'b0_0000_001;
   endtask

   task automatic test_vectors(input string name, input logic [3:0] x, input logic [3:0] y,
                               input logic ci, input logic e);
      drive(e, x, y, ci);
      @(posedge clk); #1;
      got_v = {valid, sum, cout, ovf, zero};
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard_empty got=%b", name, got_v);
      end else begin
         exp_v = sb_q.pop_front();
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s a=%b b=%b cin=%b en=%b got=%b exp=%b", name, x, y, ci, e, got_v, exp_v);
         end
      end
   endtask

   task automatic test_basic;
      test_vectors("basic_0", 4'b0000, 4'b0000, 1'b0, 1'b1);
      test_vectors("basic_1", 4'b0011, 4'b0101, 1'b0, 1'b1);
      test_vectors("basic_2", 4'b1111, 4'b0001, 1'b1, 1'b1);
      test_vectors("basic_3", 4'b1010, 4'b0101, 1'b0, 1'b1);
      test_vectors("basic_4", 4'b1001, 4'b1001, 1'b1, 1'b1);
   endtask

   task automatic test_hold;
      test_vectors("hold_load", 4'b0011, 4'b0101, 1'b0, 1'b1);
      test_vectors("hold_off", 4'b1111, 4'b1111, 1'b0, 1'b0);
      test_vectors("hold_off2", 4'b0111, 4'b0001, 1'b1, 1'b0);
   endtask

   task automatic test_wrap_zero;
      test_vectors("wrap_zero", 4'b1111, 4'b0000, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 512; i++)
         test_vectors("exhaustive", 4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1);
   endtask

   task automatic test_reset_midstream;
      test_vectors("mid_pre", 4'b0110, 4'b0111, 1'b0, 1'b1);
      @(negedge clk);
      en = 1'b1; a = 4'b0101; b = 4'b0101; cin = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({valid, sum, cout, ovf, zero} !== 8'b0_0000_001) begin
         failures++;
         $display("FAIL mid_reset_async got=%b exp=%b", {valid, sum, cout, ovf, zero}, 8'b0_0000_001);
      end
      @(posedge clk); #1;
      checks++;
      if ({valid, sum, cout, ovf, zero} !== 8'b0_0000_001) begin
         failures++;
         $display("FAIL mid_reset_no_valid got=%b exp=%b", {valid, sum, cout, ovf, zero}, 8'b0_0000_001);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
      last_v = 8'b0_0000_001;
      test_vectors("mid_post", 4'b1000, 4'b1000, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_hold;
      test_wrap_zero;
      test_back_to_back;
      test_reset_midstream;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adder_4bit.md
# adder_4bit

Registered 4-bit ripple-carry adder with carry-in and carry-out. It is the basic arithmetic slice used by wider datapaths: it adds two 4-bit operands plus a carry-in and presents sum, carry-out and status flags one clock after an enabled input sample. Its combinational core is a chain of four full-adder cells, so it can be cascaded or reused at the cell level.

## Interface
Parameters: none; the width is fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; when high, the operands are captured this edge
- a  input  4  operand A (unsigned, or two's complement for `ovf`)
- b  input  4  operand B
- cin  input  1  carry-in
- sum  output  4  registered (a + b + cin) mod 16
- cout  output  1  registered carry out of bit 3
- ovf  output  1  registered signed overflow: carry into bit 3 XOR carry out of bit 3
- zero  output  1  registered flag, high when sum == 4'b0000
- valid  output  1  high for the cycle after an enabled sample

## Operation
- Combinational core: four full-adder stages.
  - Stage i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = cin. The core's carry-out is c[4].
- Full 5-bit result: {cout, sum} = a + b + cin. The range is 0..31; no saturation.
- ovf = c[3] ^ c[4]. It is meaningful only for signed interpretation and is always computed.
- zero is derived from the 4-bit sum only. It ignores cout, so 1111+0001 gives zero=1 with cout=1.
- When en=1 on a rising edge, sum, cout, ovf and zero load the core results, and valid=1.
- When en=0, sum, cout, ovf and zero hold their previous values, and valid=0.

## Timing
- Latency is 1 cycle: operands present with en=1 before edge N produce results from edge N onward.
- Throughput is one operation per cycle. Back-to-back enabled samples each produce a valid pulse.
- Reset (rst_n=0) takes effect asynchronously and regardless of clk.
  - Reset values: sum=0000, cout=0, ovf=0, zero=1, valid=0.
- Reset release is synchronised by the system. The first edge with rst_n=1 and en=1 captures normally.
- Reset asserted mid-operation discards the in-flight result. valid does not assert for the sample captured on that edge.
- Inputs must be stable for the setup time around the rising edge. The combinational path is four carry stages plus the flag logic.
- There is no handshake back-pressure; the consumer must take the result while valid=1.

## Structure
- Sub-module `full_adder` has ports a, b, cin, sum, cout and is purely combinational. It is instantiated four times with a generate loop or explicit chain.
- The top level holds the carry chain wiring, the flag logic and the output registers.
- No shared package is needed. The width constant WIDTH=4 and the reset value constants are local to the top level.
  - If a project package exists, it holds only the reset-value constants.

## Test plan
- Reset: assert rst_n=0 with random inputs and en=1 -> immediately sum=0000, cout=0, ovf=0, zero=1, valid=0.
- Basic vectors, one per cycle with en=1, each checked the following cycle:
  - 0000+0000, cin 0 -> sum 0000, cout 0, zero 1, ovf 0.
  - 0011+0101, cin 0 -> sum 1000, cout 0, ovf 1.
  - 1111+0001, cin 1 -> sum 0001, cout 1, ovf 0.
  - 1010+0101, cin 0 -> sum 1111, cout 0, ovf 0.
  - 1001+1001, cin 1 -> sum 0011, cout 1, ovf 1.
- Hold: apply 0011+0101 with en=1, then change inputs to 1111+1111 with en=0 -> sum stays 1000 and valid drops to 0.
- Wrap and zero: 1111+0000, cin 1 -> sum 0000, cout 1, zero 1, ovf 0.
- Exhaustive: all 512 combinations of a, b, cin with en=1, checked against the model {cout,sum}=a+b+cin with ovf and zero per the Operation rules. This also exercises the valid pulse on every cycle.
- Reset mid-stream: assert rst_n between two enabled samples -> outputs return to reset values at once, and no valid pulse appears for the interrupted sample.
